score_record_bank: RTL and testbench
====================================

# score_record_bank

Registered score store and per-user averaging engine for learning mode. Sits between the learning core's `finished`/`score` outputs and the score-to-level display conversion. Holds a 4-user × 3-song record array, writes a slot on each completed session, and computes the user's average with a sequential divide-by-3. Record storage and the averaging engine are fully clocked; no combinational writes.

## Interface
- `SCORE_W`, 41, score width in bits.
- `AVG_W`, 43, sum width; equals `SCORE_W` + 2.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `finished`  in  1  level, high while the learning core shows a completed result.
- `score`  in  SCORE_W  score of the completed session; valid while `finished` is high.
- `user`  in  2  current user, 0–3.
- `song_num`  in  2  song slot 0–2; 3 selects the user's average.
- `rec_score`  out  SCORE_W  registered record of {`user`,`song_num`}, or the average when `song_num`==3.
- `avg_valid`  out  1  high when `rec_score` holds a completed average for the current user.
- `busy`  out  1  high while the averaging FSM is not in IDLE.
- `wr_ack`  out  1  one-cycle pulse the cycle after a record write.

## Operation
- Write: on the rising edge of `finished` (`finished` & ~`finished_q`) with `song_num`≠3, `record[{user,song_num}]` ← `score` (overwrite). `wr_ack` pulses on the next cycle.
  - A rising edge with `song_num`==3 is ignored: no write, no `wr_ack`.
- Read, `song_num`∈0..2: `rec_score` ← `record[{user,song_num}]`, registered.
- Read, `song_num`==3: `rec_score` ← `avg_q`, the last completed quotient. `avg_valid` = `avg_done` & (`avg_user`==`user`).
- Recompute trigger: sets `pending` on any of the following:
  - the first cycle after reset;
  - a change of `user`;
  - a write to the current user's slots.
- FSM states: IDLE, SUM, DIV, DONE.
  - IDLE: if `pending`, go to SUM and clear `pending`.
  - SUM: latch `avg_user`←`user`; `sum` = zero-extended r0+r1+r2 (AVG_W bits).
  - DIV: restoring division by 3, one quotient bit per cycle, MSB first, 43 cycles. Remainder is 2 bits. Quotient is truncated to SCORE_W (fits, since max sum/3 < 2^41).
  - DONE: `avg_q`←quotient, `avg_done`←1, go to IDLE.
- `avg_done` clears on entering SUM.
- Boundary cases:
  - `user` change during SUM/DIV: abort, return to SUM next cycle with the new user.
  - Write to `avg_user` during DIV: the division completes, and `pending` forces an immediate recompute. `avg_valid` stays low until the recompute finishes.
  - Write to a different user during DIV: the current division continues; no recompute for that user.
  - Simultaneous write and user change: the write targets the new `user`; a single recompute runs.
  - Reset mid-operation: all records ← 0, `avg_q` ← 0, FSM ← IDLE, `pending` ← 1.

## Timing
- Reset values: `rec_score`=0, `avg_valid`=0, `busy`=0, `wr_ack`=0, records=0, `finished_q`=0.
- Write latency:
  - `wr_ack` is high in cycle t+1 after a rising edge sampled at t.
  - `rec_score` reflects the new value at t+2.
- Read latency: 1 cycle from a `user`/`song_num` change.
- Average latency: trigger sampled at t gives `pending`=1 at t+1, SUM at t+2, DIV at t+3..t+45, DONE at t+46. `avg_valid` and the new `rec_score` are visible at t+47.
- `busy` is high from SUM through DONE inclusive.
- `finished` held high for many cycles produces exactly one write.

## Structure
- Shared constants go in `const.v`: `SCORE_W`, `` `SONG_AVG `` (2'b11), and the FSM state encodings `` `RB_IDLE ``/`` `RB_SUM ``/`` `RB_DIV ``/`` `RB_DONE ``.
- One sub-module, `div3_seq`: start/done handshake, AVG_W dividend, SCORE_W quotient, fixed divisor 3.
  - Instantiated once.
  - Accepts a synchronous abort.
- The record array is a 16-entry register file indexed by {`user`,`song_num`}. Slot 3 of each user is unused storage and is tied to 0.

## Test plan
- Reset, then `user`=0, `song_num`=3 → `rec_score`=0 and `avg_valid`=1 after 47 cycles; `busy` high for cycles 3–46.
- `user`=1, `song_num`=0; pulse `finished` with `score`=30 → `wr_ack` at t+1 and `rec_score`=30 at t+2. Repeat for song 1 with `score`=60 and song 2 with `score`=91; set `song_num`=3 → after recompute, `rec_score`=60 (181/3) and `avg_valid`=1.
- Hold `finished` high for 100 cycles with `score`=5 → exactly one `wr_ack`; the record equals 5.
- Pulse `finished` with `song_num`=3 and `score`=999 → no `wr_ack`; all records unchanged.
- Change `user` 2→3 at DIV cycle 20 → FSM restarts SUM; `avg_valid` stays low; the final average is user 3's.
- `score`=2^41−1 in all three user-2 slots → average = 2^41−1; no overflow.

Source files
------------

// File: rtl/score_record_bank_pkg.sv
// Shared constants, FSM state encoding and the record-index helper for the score record bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package score_record_bank_pkg;

  localparam int SCORE_W = 41;
  localparam int AVG_W   = SCORE_W + 2;

  // song_num value that selects the per-user average instead of a record slot
  localparam logic [1:0] SONG_AVG = 2'b11;

  typedef enum logic [1:0] {
    RB_IDLE = 2'd0,
    RB_SUM  = 2'd1,
    RB_DIV  = 2'd2,
    RB_DONE = 2'd3
  } rb_state_e;

  function automatic logic [3:0] rec_idx(input logic [1:0] user, input logic [1:0] song);
    return {user, song};
  endfunction

endpackage

// File: rtl/score_record_bank_if.sv
// Bundle between the learning core / display side and the score record bank.
// Latency: n/a (wires only).
// Backpressure: none; finished is a level, wr_ack a pulse, everything else is state.
// master: drives finished/score/user/song_num, observes rec_score/avg_valid/busy/wr_ack.
// slave : the record bank.
interface score_record_bank_if;
  import score_record_bank_pkg::*;

  logic               finished;
  logic [SCORE_W-1:0] score;
  logic [1:0]         user;
  logic [1:0]         song_num;
  logic [SCORE_W-1:0] rec_score;
  logic               avg_valid;
  logic               busy;
  logic               wr_ack;

  modport master (
    output finished, score, user, song_num,
    input  rec_score, avg_valid, busy, wr_ack
  );

  modport slave (
    input  finished, score, user, song_num,
    output rec_score, avg_valid, busy, wr_ack
  );

endinterface

// File: rtl/score_record_bank_div3_seq.sv
// Sequential restoring divide-by-3: one quotient bit per cycle, MSB first.
// Latency: i_start sampled at t, AVG_W step cycles t+1..t+AVG_W, o_done high in the last step cycle.
// Backpressure: none; i_abort (wins over i_start) drops the running division at once.
// Ports: clk, rst_n (sync, active-low), i_start/i_dividend load, i_abort,
//        o_done (final step this cycle), o_quot (valid the cycle after o_done).
module score_record_bank_div3_seq
  import score_record_bank_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [AVG_W-1:0]   i_dividend,
  output logic               o_done,
  output logic [SCORE_W-1:0] o_quot
);

  localparam logic [5:0] STEPS = 6'(AVG_W);

  logic [AVG_W-1:0]   r_dvd;
  logic [SCORE_W-1:0] r_quo;
  logic [1:0]         r_rem;
  logic [5:0]         r_cnt;
  logic               r_run;

  logic [2:0] w_trial;
  logic [2:0] w_sub;
  logic       w_qbit;
  logic [1:0] w_rem_nxt;

  // Remainder is always 0..2, so the trial value {rem, next bit} is 0..5.
  assign w_trial   = {r_rem, r_dvd[AVG_W-1]};
  assign w_qbit    = (w_trial >= 3'd3);
  assign w_sub     = w_trial - 3'd3;
  assign w_rem_nxt = w_qbit ? w_sub[1:0] : w_trial[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dvd <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_abort) begin
      r_run <= 1'b0;
    end else if (i_start) begin
      r_dvd <= i_dividend;
      r_quo <= '0;
      r_rem <= '0;
      r_cnt <= STEPS;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_dvd <= {r_dvd[AVG_W-2:0], 1'b0};
      // Quotient register is SCORE_W wide: the two top quotient bits shift out,
      // they are always zero because the dividend is at most 3*(2^SCORE_W-1).
      r_quo <= {r_quo[SCORE_W-2:0], w_qbit};
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt - 6'd1;
      if (r_cnt == 6'd1) r_run <= 1'b0;
    end
  end

  assign o_done = r_run & (r_cnt == 6'd1);
  assign o_quot = r_quo;

endmodule

// File: rtl/score_record_bank.sv
// 4-user x 3-song registered score store with a sequential per-user average (sum / 3).
// Latency: wr_ack t+1 after a finished rise at t, record readable t+2; reads 1 cycle; average t+47 after trigger.
// Backpressure: none; triggers arriving while busy are folded into one pending recompute.
// Ports: clk, rst_n (sync, active-low), bus (slave side of score_record_bank_if).
module score_record_bank
  import score_record_bank_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  score_record_bank_if.slave   bus
);

  logic               r_finished_q;
  logic [SCORE_W-1:0] r_rec [16];
  logic               r_wr_ack;
  logic [SCORE_W-1:0] r_rec_score;
  logic               r_pending;
  rb_state_e          r_state;
  rb_state_e          w_state_nxt;
  logic [1:0]         r_avg_user;
  logic [1:0]         r_user_q;
  logic [SCORE_W-1:0] r_avg_q;
  logic               r_avg_done;

  logic               w_wr;
  logic               w_user_chg;
  logic               w_trig;
  logic               w_start;
  logic               w_abort;
  logic               w_pend_set;
  logic               w_pend_clr;
  logic               w_div_done;
  logic [SCORE_W-1:0] w_quot;
  logic [AVG_W-1:0]   w_sum;
  logic [SCORE_W-1:0] w_rd_dat;

  // Only the rising edge of the level 'finished' writes; slot 3 is the average selector.
  assign w_wr       = bus.finished & ~r_finished_q & (bus.song_num != SONG_AVG);
  assign w_user_chg = (bus.user != r_user_q);
  assign w_trig     = w_user_chg | w_wr;

  assign w_sum = AVG_W'(r_rec[rec_idx(bus.user, 2'd0)])
               + AVG_W'(r_rec[rec_idx(bus.user, 2'd1)])
               + AVG_W'(r_rec[rec_idx(bus.user, 2'd2)]);

  // Slot 3 of every user is never written (w_wr excludes SONG_AVG) and stays at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_rec[i] <= '0;
    end else if (w_wr) begin
      r_rec[rec_idx(bus.user, bus.song_num)] <= bus.score;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RB_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A trigger seen in IDLE while pending is already set needs no extra run: the
  // SUM that follows sees the new user and the freshly written record.
  // A user change while busy restarts SUM directly instead of queueing.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    case (r_state)
      RB_IDLE: begin
        if (r_pending) begin
          w_state_nxt = RB_SUM;
          w_pend_clr  = 1'b1;
        end else begin
          w_pend_set  = w_trig;
        end
      end
      RB_SUM: begin
        w_start = 1'b1;
        if (w_user_chg) begin
          w_abort = 1'b1;
        end else begin
          w_state_nxt = RB_DIV;
          w_pend_set  = w_wr;
        end
      end
      RB_DIV: begin
        if (w_user_chg) begin
          w_abort     = 1'b1;
          w_state_nxt = RB_SUM;
        end else begin
          w_pend_set = w_wr;
          if (w_div_done) w_state_nxt = RB_DONE;
        end
      end
      RB_DONE: begin
        w_state_nxt = RB_IDLE;
        w_pend_set  = w_trig;
      end
      default: w_state_nxt = RB_IDLE;
    endcase
  end

  score_record_bank_div3_seq u_div3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_abort    (w_abort),
    .i_dividend (w_sum),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  // In DONE the quotient bypasses avg_q so the new average shows with avg_valid.
  always_comb begin
    w_rd_dat = r_rec[rec_idx(bus.user, bus.song_num)];
    if (bus.song_num == SONG_AVG) w_rd_dat = (r_state == RB_DONE) ? w_quot : r_avg_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_finished_q <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_rec_score  <= '0;
      r_pending    <= 1'b1;
      r_avg_user   <= '0;
      r_user_q     <= '0;
      r_avg_q      <= '0;
      r_avg_done   <= 1'b0;
    end else begin
      r_finished_q <= bus.finished;
      r_wr_ack     <= w_wr;
      r_user_q     <= bus.user;
      r_rec_score  <= w_rd_dat;
      if (w_pend_clr)      r_pending <= 1'b0;
      else if (w_pend_set) r_pending <= 1'b1;
      if (r_state == RB_SUM) r_avg_user <= bus.user;
      if (r_state == RB_DONE) begin
        r_avg_q    <= w_quot;
        r_avg_done <= 1'b1;
      end
      if (w_state_nxt == RB_SUM) r_avg_done <= 1'b0;
    end
  end

  assign bus.rec_score = r_rec_score;
  // A queued recompute hides the previous (now stale) average.
  assign bus.avg_valid = r_avg_done & (r_avg_user == bus.user) & ~r_pending;
  assign bus.busy      = (r_state != RB_IDLE);
  assign bus.wr_ack    = r_wr_ack;

endmodule

// File: tb/tb_score_record_bank.sv
// Directed bench for score_record_bank: reset, writes, averaging latency, abort and reset mid-run.
module tb_score_record_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  score_record_bank_if bif();

  score_record_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] s, input logic [40:0] v);
    bif.song_num = s;
    bif.score    = v;
    bif.finished = 1'b1;
    step();
    chk("wr_ack", 64'(bif.wr_ack), 64'd1);
    bif.finished = 1'b0;
    step();
    chk("wr_ack_clr", 64'(bif.wr_ack), 64'd0);
    chk("wr_readback", 64'(bif.rec_score), 64'(v));
  endtask

  task automatic wait_valid(input string tag);
    step();
    step();
    for (int i = 0; i < 300; i++) begin
      if (bif.avg_valid && !bif.busy) break;
      step();
    end
    chk(tag, 64'(bif.avg_valid), 64'd1);
  endtask

  logic [40:0] max_s;
  logic [40:0] exp_rec [3];
  int          n_ack;

  initial begin
    max_s        = {41{1'b1}};
    bif.finished = 1'b0;
    bif.score    = '0;
    bif.user     = 2'd0;
    bif.song_num = 2'd3;

    // Reset state and first-cycle average for user 0
    repeat (3) step();
    chk("rst_rec_score", 64'(bif.rec_score), 64'd0);
    chk("rst_avg_valid", 64'(bif.avg_valid), 64'd0);
    chk("rst_busy", 64'(bif.busy), 64'd0);
    chk("rst_wr_ack", 64'(bif.wr_ack), 64'd0);
    rst_n = 1'b1;
    chk("pend_busy", 64'(bif.busy), 64'd0);
    step();
    chk("sum_busy", 64'(bif.busy), 64'd1);
    repeat (44) step();
    chk("done_busy", 64'(bif.busy), 64'd1);
    chk("done_valid_low", 64'(bif.avg_valid), 64'd0);
    step();
    chk("init_avg_valid", 64'(bif.avg_valid), 64'd1);
    chk("init_busy_low", 64'(bif.busy), 64'd0);
    chk("init_avg", 64'(bif.rec_score), 64'd0);

    // User 1: 30, 60, 91 -> 181/3 = 60
    bif.user = 2'd1;
    do_write(2'd0, 41'd30);
    do_write(2'd1, 41'd60);
    do_write(2'd2, 41'd91);
    bif.song_num = 2'd3;
    wait_valid("u1_valid");
    chk("u1_avg", 64'(bif.rec_score), 64'd60);

    // Exact average latency: 33+60+91 = 184 -> 61
    bif.song_num = 2'd0;
    bif.score    = 41'd33;
    bif.finished = 1'b1;
    step();
    chk("lat_wr_ack", 64'(bif.wr_ack), 64'd1);
    chk("lat_pend_idle", 64'(bif.busy), 64'd0);
    chk("lat_stale_hidden", 64'(bif.avg_valid), 64'd0);
    bif.finished = 1'b0;
    bif.song_num = 2'd3;
    step();
    chk("lat_sum", 64'(bif.busy), 64'd1);
    repeat (44) step();
    chk("lat_done_busy", 64'(bif.busy), 64'd1);
    chk("lat_done_valid", 64'(bif.avg_valid), 64'd0);
    step();
    chk("lat_valid", 64'(bif.avg_valid), 64'd1);
    chk("lat_idle", 64'(bif.busy), 64'd0);
    chk("lat_avg", 64'(bif.rec_score), 64'd61);

    // finished held high: exactly one write
    bif.song_num = 2'd1;
    bif.score    = 41'd5;
    bif.finished = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bif.wr_ack) n_ack++;
    end
    bif.finished = 1'b0;
    chk("hold_one_ack", 64'(n_ack), 64'd1);
    step();
    chk("hold_rec", 64'(bif.rec_score), 64'd5);
    bif.song_num = 2'd3;
    wait_valid("hold_valid");
    chk("hold_avg", 64'(bif.rec_score), 64'd43);

    // Rising edge with song_num == 3 is ignored
    bif.score    = 41'd999;
    bif.finished = 1'b1;
    step();
    chk("avgsel_no_ack", 64'(bif.wr_ack), 64'd0);
    bif.finished = 1'b0;
    step();
    chk("avgsel_no_ack2", 64'(bif.wr_ack), 64'd0);
    chk("avgsel_no_busy", 64'(bif.busy), 64'd0);
    exp_rec[0] = 41'd33;
    exp_rec[1] = 41'd5;
    exp_rec[2] = 41'd91;
    for (int s = 0; s < 3; s++) begin
      bif.song_num = 2'(s);
      step();
      chk($sformatf("avgsel_rec%0d", s), 64'(bif.rec_score), 64'(exp_rec[s]));
    end

    // User 3: 300+3+0 = 303 -> 101; user 2: all max -> max
    bif.user = 2'd3;
    do_write(2'd0, 41'd300);
    do_write(2'd1, 41'd3);
    do_write(2'd2, 41'd0);
    bif.user = 2'd2;
    do_write(2'd0, max_s);
    do_write(2'd1, max_s);
    do_write(2'd2, max_s);
    bif.song_num = 2'd3;
    wait_valid("max_valid");
    chk("max_avg", 64'(bif.rec_score), 64'(max_s));

    // User change 2->3 in DIV cycle 20 restarts SUM for user 3
    bif.song_num = 2'd0;
    bif.score    = max_s;
    bif.finished = 1'b1;
    step();
    bif.finished = 1'b0;
    bif.song_num = 2'd3;
    step();
    repeat (20) step();
    chk("abort_in_div", 64'(bif.busy), 64'd1);
    chk("abort_valid_low", 64'(bif.avg_valid), 64'd0);
    bif.user = 2'd3;
    step();
    chk("abort_sum_busy", 64'(bif.busy), 64'd1);
    chk("abort_sum_valid", 64'(bif.avg_valid), 64'd0);
    repeat (44) step();
    chk("abort_done_valid", 64'(bif.avg_valid), 64'd0);
    step();
    chk("abort_valid", 64'(bif.avg_valid), 64'd1);
    chk("abort_avg_u3", 64'(bif.rec_score), 64'd101);

    // Reset in the middle of a recompute
    bif.song_num = 2'd0;
    bif.score    = 41'd7;
    bif.finished = 1'b1;
    step();
    bif.finished = 1'b0;
    repeat (10) step();
    chk("mid_busy", 64'(bif.busy), 64'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_busy", 64'(bif.busy), 64'd0);
    chk("mid_rst_rec", 64'(bif.rec_score), 64'd0);
    chk("mid_rst_valid", 64'(bif.avg_valid), 64'd0);
    rst_n = 1'b1;
    step();
    chk("mid_rec0_clear", 64'(bif.rec_score), 64'd0);
    bif.song_num = 2'd1;
    step();
    chk("mid_rec1_clear", 64'(bif.rec_score), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
